// File: rtl/ni_inject_arbiter.sv
// ni_inject_arbiter: round-robin packet arbiter feeding one shared NI injection FIFO
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/data/last : per-requester flit stream, data packed DW bits per requester
//   req_ready           : flit accepted when high together with req_valid
//   fifo_full           : stalls the current owner
//   fifo_write_en/data  : FIFO write port
//   grant_id, busy      : current packet owner, high while a packet owns the FIFO
//   len_err, pkt_count  : sticky over-length flag, completed packet counter
module ni_inject_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 64,
  parameter int MAX_FLITS = 8,
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_write_en,
  output logic [DW-1:0]     fifo_data_in,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              len_err,
  output logic [15:0]       pkt_count
);
  localparam int CW = $clog2(MAX_FLITS + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [GW-1:0] rr_ptr, pick, idx;
  logic [CW-1:0] cnt;
  logic active, done;
  // scanning downward lets the lowest offset from rr_ptr win
  always_comb begin
    pick = rr_ptr;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NREQ);
      pick = req_valid[idx] ? idx : pick;
    end
  end
  // reset gates the datapath so a packet in flight stops writing immediately
  assign active = state == BURST && !reset;
  assign req_ready = active && !fifo_full ? NREQ'(1) << grant_id : '0;
  assign fifo_write_en = active && !fifo_full && req_valid[grant_id];
  assign done = req_last[grant_id] || cnt == CW'(MAX_FLITS - 1);
  assign busy = state == BURST;
  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NREQ; i++)
      fifo_data_in = active && grant_id == GW'(i) ? req_data[i*DW +: DW] : fifo_data_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      cnt <= '0;
      len_err <= 1'b0;
      pkt_count <= '0;
    end else if (state == IDLE) begin
      if (|req_valid) begin
        state <= BURST;
        grant_id <= pick;
      end
    end else if (fifo_write_en) begin
      if (done) begin
        state <= IDLE;
        grant_id <= '0;
        rr_ptr <= grant_id == GW'(NREQ - 1) ? '0 : grant_id + 1'b1;
        cnt <= '0;
        pkt_count <= pkt_count + 16'd1;
        len_err <= len_err | !req_last[grant_id];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ni_inject_arbiter.sv
// tb_ni_inject_arbiter: table vectors, directed sequences and a random run against a reference model
module tb_ni_inject_arbiter;
  localparam int N = 4, DW = 64, MF = 8;
  logic clk = 0, reset = 1, fifo_full = 0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*DW-1:0] req_data;
  logic fifo_write_en, busy, len_err;
  logic [DW-1:0] fifo_data_in;
  logic [1:0] grant_id;
  logic [15:0] pkt_count;
  logic [DW-1:0] src [N];
  ni_inject_arbiter #(.NREQ(N), .DW(DW), .MAX_FLITS(MF)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy), .len_err(len_err),
    .pkt_count(pkt_count)
  );
  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) req_data[i*DW +: DW] = src[i];
  typedef struct {
    bit r; logic [3:0] v, l; bit f;
    logic [3:0] rdy; bit we, bsy; logic [1:0] gid; logic [15:0] pkt;
  } vec_t;
  vec_t tab [13];
  vec_t tv;
  int checks = 0, errors = 0;
  bit mb, ml, auto_src = 1, last_we;
  int mo, mc, mr, acc [N];
  logic [15:0] mp;
  logic [DW-1:0] wlog [$];
  int gorder [$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // mode 0: reference model, 1: table record tv, 2: no check
  task automatic cyc(input bit r, input logic [N-1:0] v, input logic [N-1:0] l, input bit f, input int mode);
    logic [N-1:0] er;
    bit ewe;
    logic [DW-1:0] ed;
    @(negedge clk);
    if (auto_src) for (int i = 0; i < N; i++) src[i] = {8'(i), 24'h0, 32'(acc[i])};
    reset = r; req_valid = v; req_last = l; fifo_full = f;
    #1;
    er = (!r && mb && !f) ? N'(1) << mo : '0;
    ewe = er[mo] && v[mo];
    ed = (!r && mb) ? src[mo] : '0;
    if (mode == 1) begin
      chk("tab_ready", req_ready, tv.rdy);
      chk("tab_we", fifo_write_en, tv.we);
      chk("tab_busy", busy, tv.bsy);
      chk("tab_gid", grant_id, tv.gid);
      chk("tab_pkt", pkt_count, tv.pkt);
    end else if (mode == 0) begin
      chk("ready", req_ready, er);
      chk("we", fifo_write_en, ewe);
      chk("data", fifo_data_in, ed);
      chk("gid", grant_id, mo);
      chk("busy", busy, mb);
      chk("len_err", len_err, ml);
      chk("pkt", pkt_count, mp);
    end
    last_we = fifo_write_en;
    if (fifo_write_en) wlog.push_back(fifo_data_in);
    @(posedge clk);
    if (r) begin
      mb = 0; mo = 0; mc = 0; mr = 0; mp = 0; ml = 0;
    end else if (!mb) begin
      if (|v) begin
        for (int k = 0; k < N; k++) if (v[(mr + k) % N]) begin mo = (mr + k) % N; break; end
        mb = 1;
        gorder.push_back(mo);
      end
    end else if (ewe) begin
      acc[mo]++;
      mc++;
      if (l[mo] || mc == MF) begin
        if (!l[mo]) ml = 1;
        mp++;
        mb = 0; mr = (mo + 1) % N; mo = 0; mc = 0;
      end
    end
  endtask
  task automatic reset_dut();
    cyc(1, '0, '0, 0, 2);
    cyc(1, '0, '0, 0, 2);
    wlog.delete();
    gorder.delete();
    for (int i = 0; i < N; i++) acc[i] = 0;
    auto_src = 1;
  endtask
  initial begin
    logic [3:0] l;
    logic [5:0] pat;
    int stalls;
    for (int i = 0; i < N; i++) begin src[i] = '0; acc[i] = 0; end
    tab[0]  = '{0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 0};
    tab[1]  = '{0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0, 0};
    tab[2]  = '{0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 1, 0, 0};
    tab[3]  = '{0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 0, 0};
    tab[4]  = '{0, 4'b0101, 4'b0100, 0, 4'b0000, 0, 0, 0, 1};
    tab[5]  = '{0, 4'b0101, 4'b0100, 0, 4'b0100, 1, 1, 2, 1};
    tab[6]  = '{0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 0, 2};
    tab[7]  = '{0, 4'b0000, 4'b0000, 0, 4'b0001, 0, 1, 0, 2};
    tab[8]  = '{0, 4'b1000, 4'b1000, 0, 4'b0001, 0, 1, 0, 2};
    tab[9]  = '{0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 0, 2};
    tab[10] = '{1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 3};
    tab[11] = '{0, 4'b1010, 4'b0000, 0, 4'b0000, 0, 0, 0, 0};
    tab[12] = '{0, 4'b1010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0};
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      tv = tab[i];
      cyc(tv.r, tv.v, tv.l, tv.f, 1);
    end
    // 3-flit packet from requester 0 with fixed data
    reset_dut();
    auto_src = 0;
    src[0] = 64'hA5A5A5A5A5A5A5A5; cyc(0, 4'b0001, 4'b0000, 0, 0);
    cyc(0, 4'b0001, 4'b0000, 0, 0);
    src[0] = 64'hA5A5A5A5A5A5A1A5; cyc(0, 4'b0001, 4'b0000, 0, 0);
    src[0] = 64'hA5A5A5A5A5A5A4A5; cyc(0, 4'b0001, 4'b0001, 0, 0);
    #1;
    chk("s1_writes", wlog.size(), 3);
    chk("s1_w0", wlog[0], 64'hA5A5A5A5A5A5A5A5);
    chk("s1_w1", wlog[1], 64'hA5A5A5A5A5A5A1A5);
    chk("s1_w2", wlog[2], 64'hA5A5A5A5A5A5A4A5);
    chk("s1_pkt", pkt_count, 1);
    cyc(0, 4'b0011, 4'b0000, 0, 0);
    #1;
    chk("s1_rr_next", grant_id, 1);
    // all four requesters, 2-flit packets
    reset_dut();
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < N; i++) l[i] = acc[i] % 2 == 1;
      cyc(0, 4'b1111, l, 0, 0);
    end
    chk("s2_grants", gorder.size(), 5);
    for (int k = 0; k < 5; k++) chk("s2_order", gorder[k], k % 4);
    for (int j = 0; j < 10; j++) begin
      chk("s2_owner", wlog[j][63:56], j / 2 % 4);
      chk("s2_seq", wlog[j][31:0], (j >= 8 ? 2 : 0) + j % 2);
    end
    // owner 2 stalled by a full FIFO for 4 cycles
    reset_dut();
    stalls = 0;
    cyc(0, 4'b0100, 4'b0000, 0, 0);
    cyc(0, 4'b0100, 4'b0000, 0, 0);
    for (int c = 0; c < 4; c++) begin
      cyc(0, 4'b0110, 4'b0000, 1, 0);
      stalls += (!last_we && !req_ready[2]) ? 1 : 0;
    end
    cyc(0, 4'b0100, 4'b0100, 0, 0);
    chk("s3_stalls", stalls, 4);
    chk("s3_writes", wlog.size(), 2);
    chk("s3_w0", wlog[0], {8'd2, 24'h0, 32'd0});
    chk("s3_w1", wlog[1], {8'd2, 24'h0, 32'd1});
    // requester 1 never sends a tail
    reset_dut();
    for (int c = 0; c < 9; c++) cyc(0, 4'b0010, 4'b0000, 0, 0);
    #1;
    chk("s4_writes", wlog.size(), 8);
    chk("s4_len_err", len_err, 1);
    chk("s4_busy", busy, 0);
    chk("s4_pkt", pkt_count, 1);
    cyc(0, 4'b0010, 4'b0000, 0, 0);
    chk("s4_regrant_idle", last_we, 0);
    cyc(0, 4'b0010, 4'b0000, 0, 0);
    chk("s4_ninth", wlog[8][31:0], 8);
    // reset in the middle of requester 3's packet
    reset_dut();
    cyc(0, 4'b1000, 4'b0000, 0, 0);
    cyc(0, 4'b1000, 4'b0000, 0, 0);
    cyc(0, 4'b1000, 4'b0000, 0, 0);
    cyc(1, 4'b1000, 4'b0000, 0, 0);
    cyc(1, 4'b1000, 4'b0000, 0, 0);
    cyc(0, 4'b1010, 4'b0000, 0, 0);
    #1;
    chk("s5_writes", wlog.size(), 2);
    chk("s5_regrant", grant_id, 1);
    chk("s5_pkt", pkt_count, 0);
    chk("s5_len_err", len_err, 0);
    // back-to-back single-flit packets
    reset_dut();
    pat = '0;
    for (int c = 0; c < 6; c++) begin
      cyc(0, 4'b0010, 4'b0010, 0, 0);
      pat[c] = last_we;
    end
    #1;
    chk("s6_pattern", pat, 6'b101010);
    chk("s6_pkt", pkt_count, 3);
    // random traffic against the model
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) l[i] = $urandom_range(3) == 0;
      cyc($urandom_range(199) == 0, 4'($urandom), l, $urandom_range(3) == 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
